// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage RV32IM pipeline
//
// Purpose:
//   Drives the enable/flush controls of the PC and every pipeline register.
//   It combines three sources, listed from highest to lowest priority in IDLE:
//     1. taken branch/jump redirect flush
//     2. multi-cycle MUL/DIV occupancy in EX
//     3. load-use bubble insertion
//   While an MDU op is in flight (BUSY), redirect and load-use are ignored.
//
// Parameters:
//   MUL_LAT  cycles a MUL/MULH* op occupies EX (>=1)
//   DIV_LAT  cycles a DIV/DIVU/REM/REMU op occupies EX (>=1)
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   is_taken             EX-stage branch/jump resolved taken
//   instr_D, instr_E     instruction words in ID and EX
//   mdu_start            one-cycle pulse, MDU latches EX operands
//   mdu_busy             MDU op in flight
//   pc_enable            PC enable
//   <stage>_enable/flush enables and flush-to-NOP for IF/ID, ID/EX, EX/MEM, ME/WB
//
// Optional feature (macro PIPE_STALL_PERF_EN):
//   adds 32-bit wrapping counters perf_stall_cyc, perf_flush_cnt, perf_lu_cnt.

module pipe_stall_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_taken,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        pc_enable,
  output logic        IF_ID_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_enable,
  output logic        ID_EX_flush,
  output logic        EX_ME_enable,
  output logic        EX_ME_flush,
  output logic        ME_WB_enable,
  output logic        ME_WB_flush
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] MUL_L = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Decode
  logic [6:0]    w_op_D;
  logic [6:0]    w_op_E;
  logic [4:0]    w_rd_E;
  logic [4:0]    w_rs1_D;
  logic [4:0]    w_rs2_D;
  logic          w_mdu_op_E;
  logic [CW-1:0] w_lat;
  logic          w_rs1_used;
  logic          w_rs2_used;
  logic          w_load_use;
  logic          w_branch;
  logic          w_br_fire;
  logic          w_lu_fire;
  logic          w_unused;

  assign w_op_D  = instr_D[6:0];
  assign w_op_E  = instr_E[6:0];
  assign w_rd_E  = instr_E[11:7];
  assign w_rs1_D = instr_D[19:15];
  assign w_rs2_D = instr_D[24:20];

  assign w_mdu_op_E = (w_op_E == OP_REG) && (instr_E[31:25] == 7'b0000001);
  // funct3[2] separates DIV/DIVU/REM/REMU from the MUL family
  assign w_lat      = instr_E[14] ? DIV_L : MUL_L;

  assign w_rs1_used = !((w_op_D == OP_LUI) || (w_op_D == OP_AUIPC) || (w_op_D == OP_JAL));
  assign w_rs2_used = (w_op_D == OP_REG) || (w_op_D == OP_STORE) || (w_op_D == OP_BRANCH);

  assign w_load_use = (w_op_E == OP_LOAD) && (w_rd_E != 5'd0) &&
                      (((w_rs1_D == w_rd_E) && w_rs1_used) ||
                       ((w_rs2_D == w_rd_E) && w_rs2_used));

  assign w_branch = is_taken &&
                    ((w_op_E == OP_BRANCH) || (w_op_E == OP_JAL) || (w_op_E == OP_JALR));

  assign w_unused = &{1'b0, instr_D[31:25], instr_D[14:7], instr_E[24:15], instr_E[13:12]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. The start cycle counts as the first stalled cycle, so
  // BUSY lasts lat-1 cycles (cnt runs lat-2 .. 0) before the DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!w_branch && w_mdu_op_E) begin
          if (w_lat == ONE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = w_lat - TWO;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. Reset overrides combinationally so the outputs sit at their
  // defaults for the whole reset window, whatever is in ID/EX.
  always_comb begin
    mdu_start    = 1'b0;
    mdu_busy     = 1'b0;
    pc_enable    = 1'b1;
    IF_ID_enable = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_enable = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_ME_enable = 1'b1;
    EX_ME_flush  = 1'b0;
    ME_WB_enable = 1'b1;
    ME_WB_flush  = 1'b0;
    w_br_fire    = 1'b0;
    w_lu_fire    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_branch) begin
            w_br_fire    = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            ID_EX_enable = 1'b0;
            pc_enable    = 1'b1;
          end else if (w_mdu_op_E) begin
            mdu_start    = 1'b1;
            pc_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_enable = 1'b0;
            EX_ME_flush  = 1'b1;
          end else if (w_load_use) begin
            w_lu_fire    = 1'b1;
            pc_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_flush  = 1'b1;
          end
        end
        S_BUSY: begin
          mdu_busy     = 1'b1;
          pc_enable    = 1'b0;
          IF_ID_enable = 1'b0;
          ID_EX_enable = 1'b0;
          EX_ME_flush  = 1'b1;
        end
        // DONE: the MDU instruction advances with its result; no restart
        default: ;
      endcase
    end
  end

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (!pc_enable) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (w_br_fire)  perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (w_lu_fire)  perf_lu_cnt    <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl

module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_taken;
  logic [31:0] instr_D;
  logic [31:0] instr_E;

  logic mdu_start, mdu_busy, pc_enable, IF_ID_enable, IF_ID_flush, ID_EX_enable;
  logic ID_EX_flush, EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush;
  logic d1_mdu_start, d1_mdu_busy, d1_pc_enable, d1_IF_ID_enable, d1_IF_ID_flush;
  logic d1_ID_EX_enable, d1_ID_EX_flush, d1_EX_ME_enable, d1_EX_ME_flush;
  logic d1_ME_WB_enable, d1_ME_WB_flush;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
  logic [31:0] d1_perf_stall_cyc, d1_perf_flush_cnt, d1_perf_lu_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .is_taken(is_taken), .instr_D(instr_D), .instr_E(instr_E),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .pc_enable(pc_enable),
    .IF_ID_enable(IF_ID_enable), .IF_ID_flush(IF_ID_flush),
    .ID_EX_enable(ID_EX_enable), .ID_EX_flush(ID_EX_flush),
    .EX_ME_enable(EX_ME_enable), .EX_ME_flush(EX_ME_flush),
    .ME_WB_enable(ME_WB_enable), .ME_WB_flush(ME_WB_flush)
`ifdef PIPE_STALL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_lu_cnt(perf_lu_cnt)
`endif
  );

  pipe_stall_ctrl #(.MUL_LAT(1), .DIV_LAT(33)) dut1 (
    .clk(clk), .rst(rst), .is_taken(is_taken), .instr_D(instr_D), .instr_E(instr_E),
    .mdu_start(d1_mdu_start), .mdu_busy(d1_mdu_busy), .pc_enable(d1_pc_enable),
    .IF_ID_enable(d1_IF_ID_enable), .IF_ID_flush(d1_IF_ID_flush),
    .ID_EX_enable(d1_ID_EX_enable), .ID_EX_flush(d1_ID_EX_flush),
    .EX_ME_enable(d1_EX_ME_enable), .EX_ME_flush(d1_EX_ME_flush),
    .ME_WB_enable(d1_ME_WB_enable), .ME_WB_flush(d1_ME_WB_flush)
`ifdef PIPE_STALL_PERF_EN
    , .perf_stall_cyc(d1_perf_stall_cyc), .perf_flush_cnt(d1_perf_flush_cnt), .perf_lu_cnt(d1_perf_lu_cnt)
`endif
  );

  // {start, busy, pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exme_en, exme_fl, mewb_en, mewb_fl}
  logic [10:0] vec, vec1;
  assign vec  = {mdu_start, mdu_busy, pc_enable, IF_ID_enable, IF_ID_flush, ID_EX_enable,
                 ID_EX_flush, EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush};
  assign vec1 = {d1_mdu_start, d1_mdu_busy, d1_pc_enable, d1_IF_ID_enable, d1_IF_ID_flush,
                 d1_ID_EX_enable, d1_ID_EX_flush, d1_EX_ME_enable, d1_EX_ME_flush,
                 d1_ME_WB_enable, d1_ME_WB_flush};

  localparam logic [10:0] V_DEF   = 11'b0_0_1_1_0_1_0_1_0_1_0;
  localparam logic [10:0] V_START = 11'b1_0_0_0_0_0_0_1_1_1_0;
  localparam logic [10:0] V_BUSY  = 11'b0_1_0_0_0_0_0_1_1_1_0;
  localparam logic [10:0] V_LU    = 11'b0_0_0_0_0_1_1_1_0_1_0;
  localparam logic [10:0] V_BR    = 11'b0_0_1_1_1_0_1_1_0_1_0;

  localparam logic [31:0] I_NOP   = 32'h0000_0013;
  localparam logic [31:0] I_MUL   = 32'h0220_81B3; // mul  x3,x1,x2
  localparam logic [31:0] I_DIV   = 32'h0220_C1B3; // div  x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD   = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] I_LUI   = 32'h0002_82B7; // lui  x5 (rs1 field = 5)
  localparam logic [31:0] I_SW    = 32'h0050_A023; // sw   x5,0(x1)
  localparam logic [31:0] I_ADDI  = 32'h0050_8313; // addi x6,x1,5 (rs2 field = 5)
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low, n_busy, n_start;
    logic done_seen;

    // Reset with hostile inputs: outputs must sit at defaults
    rst = 1'b1; is_taken = 1'b1; instr_E = I_DIV; instr_D = I_ADD;
    @(negedge clk); check("rst_out", 32'(vec), 32'(V_DEF));
    check("rst_out1", 32'(vec1), 32'(V_DEF));
    tick();
    rst = 1'b0; is_taken = 1'b0; instr_E = I_NOP; instr_D = I_NOP;
    @(negedge clk); check("idle_after_rst", 32'(vec), 32'(V_DEF));

    // MUL, MUL_LAT=2: start, busy, done
    tick(); instr_E = I_MUL;
    @(negedge clk); check("mul_c0", 32'(vec), 32'(V_START));
    tick(); @(negedge clk); check("mul_c1", 32'(vec), 32'(V_BUSY));
    tick(); @(negedge clk); check("mul_done", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_NOP;
    @(negedge clk); check("mul_after", 32'(vec), 32'(V_DEF));

    // Load-use
    tick(); instr_E = I_LW5; instr_D = I_ADD;
    @(negedge clk); check("lu_add", 32'(vec), 32'(V_LU));
    tick(); instr_E = I_NOP;
    @(negedge clk); check("lu_bubble_gone", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_LW5; instr_D = I_LUI;
    @(negedge clk); check("lu_lui", 32'(vec), 32'(V_DEF));
    tick(); instr_D = I_SW;
    @(negedge clk); check("lu_sw_rs2", 32'(vec), 32'(V_LU));
    tick(); instr_D = I_ADDI;
    @(negedge clk); check("lu_addi_rs2_unused", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_LW0; instr_D = I_ADD;
    @(negedge clk); check("lu_rd_x0", 32'(vec), 32'(V_DEF));

    // Branch flush
    tick(); instr_E = I_BEQ; instr_D = I_NOP; is_taken = 1'b1;
    @(negedge clk); check("br_beq", 32'(vec), 32'(V_BR));
    tick(); instr_E = I_JAL;
    @(negedge clk); check("br_jal", 32'(vec), 32'(V_BR));
    tick(); instr_E = I_ADD;
    @(negedge clk); check("br_add_taken", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_BEQ; is_taken = 1'b0;
    @(negedge clk); check("br_not_taken", 32'(vec), 32'(V_DEF));

    // Full DIV: 33 stalled cycles, 32 of them BUSY
    tick(); instr_E = I_DIV; instr_D = I_ADD;
    n_low = 0; n_busy = 0; done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pc_enable) begin
        check("div_done", 32'(vec), 32'(V_DEF));
        done_seen = 1'b1;
        break;
      end
      n_low++;
      if (mdu_busy) n_busy++;
      if (i == 0) check("div_c0", 32'(vec), 32'(V_START));
      tick();
    end
    check("div_done_seen", 32'(done_seen), 32'd1);
    check("div_stall_cycles", n_low, 33);
    check("div_busy_cycles", n_busy, 32);
    tick(); instr_E = I_NOP; instr_D = I_NOP;
    @(negedge clk); check("div_after", 32'(vec), 32'(V_DEF));

    // DIV aborted by reset in cycle 10
    tick(); instr_E = I_DIV;
    @(negedge clk); check("abort_c0", 32'(vec), 32'(V_START));
    for (int i = 1; i < 10; i++) begin
      tick(); @(negedge clk); check("abort_busy", 32'(vec), 32'(V_BUSY));
    end
    tick(); rst = 1'b1; #1;
    check("abort_immediate", 32'(vec), 32'(V_DEF));
    @(negedge clk); check("abort_held", 32'(vec), 32'(V_DEF));
    tick(); rst = 1'b0; instr_E = I_NOP;
    @(negedge clk); check("abort_released", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_MUL;
    @(negedge clk); check("post_abort_mul", 32'(vec), 32'(V_START));
    tick(); @(negedge clk); check("post_abort_busy", 32'(vec), 32'(V_BUSY));
    tick(); @(negedge clk); check("post_abort_done", 32'(vec), 32'(V_DEF));
    tick(); instr_E = I_NOP;
    tick(); tick(); tick();

    // Back-to-back MUL with MUL_LAT=1: starts on cycles 0 and 2 only
    instr_E = I_MUL; n_start = 0;
    @(negedge clk); check("b2b_c0", 32'(vec1), 32'(V_START)); n_start += int'(d1_mdu_start);
    tick(); @(negedge clk); check("b2b_c1", 32'(vec1), 32'(V_DEF)); n_start += int'(d1_mdu_start);
    tick(); @(negedge clk); check("b2b_c2", 32'(vec1), 32'(V_START)); n_start += int'(d1_mdu_start);
    tick(); @(negedge clk); check("b2b_c3", 32'(vec1), 32'(V_DEF)); n_start += int'(d1_mdu_start);
    check("b2b_start_count", n_start, 2);
    tick(); instr_E = I_NOP;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives the enable and flush controls of every pipeline register and the PC, combining three sources:
- taken-branch/jump redirect flush;
- load-use bubble insertion;
- a multi-cycle MUL/DIV (MDU) occupancy FSM that freezes the front end while the EX-stage MDU op completes.

It sits beside the pipeline registers and takes decoded instruction words from the ID and EX stages.

Parameters:
MUL_LAT, 2, cycles an MUL/MULH* op occupies EX (>=1)
DIV_LAT, 33, cycles a DIV/DIVU/REM/REMU op occupies EX (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
is_taken  in  1  EX-stage branch/jump resolved taken
instr_D  in  32  instruction in ID
instr_E  in  32  instruction in EX
mdu_start  out  1  one-cycle pulse: MDU latches EX operands
mdu_busy  out  1  MDU op in flight (state BUSY)
pc_enable  out  1  PC register enable
IF_ID_enable  out  1  IF/ID enable
IF_ID_flush  out  1  IF/ID flush to NOP
ID_EX_enable  out  1  ID/EX enable
ID_EX_flush  out  1  ID/EX flush to NOP
EX_ME_enable  out  1  EX/MEM enable
EX_ME_flush  out  1  EX/MEM flush to NOP
ME_WB_enable  out  1  ME/WB enable
ME_WB_flush  out  1  ME/WB flush to NOP

Behaviour:
- Default outputs: all enables 1; all flushes, mdu_start and mdu_busy 0.
- While rst is high: state=IDLE, cnt=0, outputs forced to the defaults regardless of instr_D/instr_E.
- Decode:
  - mdu_op_E = (instr_E[6:0]==0110011) && (instr_E[31:25]==0000001).
  - is_div = instr_E[14].
  - lat = is_div ? DIV_LAT : MUL_LAT.
- Load-use detect:
  - Condition: instr_E[6:0]==0000011, rd_E!=0, and (rs1_D==rd_E && rs1 used) or (rs2_D==rd_E && rs2 used).
  - rs1 is used unless opcode_D is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - rs2 is used only when opcode_D is 0110011, 0100011 or 1100011.
- Branch flush:
  - Condition: is_taken && opcode_E in {1100011, 1101111, 1100111}.
  - Action: IF_ID_flush=1, ID_EX_flush=1, ID_EX_enable=0, pc_enable=1.
- FSM states: IDLE, BUSY, DONE. Counter cnt is $clog2(max(MUL_LAT,DIV_LAT))+1 bits wide and unsigned.
- IDLE:
  - Branch flush has the highest priority.
  - Otherwise, if mdu_op_E: mdu_start=1 (combinational, this cycle); pc_enable, IF_ID_enable and ID_EX_enable = 0; EX_ME_flush=1 (bubble into MEM).
    - lat==1 → next state DONE.
    - Otherwise cnt<=lat-2 and next state BUSY.
  - Otherwise, if load-use: pc_enable=0, IF_ID_enable=0, ID_EX_flush=1 (one bubble); stay IDLE.
- BUSY:
  - mdu_busy=1; same freeze and EX_ME_flush as the IDLE start cycle.
  - mdu_start=0; is_taken and load-use are ignored.
  - cnt==0 → next state DONE; otherwise cnt decrements.
- DONE:
  - All defaults: the MDU instruction advances to MEM with its result. No restart is allowed even though mdu_op_E is still true this cycle.
  - Next state IDLE.
- Total EX occupancy of an MDU op is exactly lat+1 cycles: lat stalled cycles plus 1 DONE cycle.
- Back-to-back MDU ops: the second op is in EX the cycle after DONE, so it starts normally from IDLE.
- Asserting reset mid-BUSY aborts the sequence immediately. mdu_start is not reissued.

Optional Feature:
PIPE_STALL_PERF_EN
- Defined: adds three 32-bit wrapping counters, reset to 0, plus output ports perf_stall_cyc, perf_flush_cnt and perf_lu_cnt.
  - perf_stall_cyc increments on every cycle with pc_enable==0.
  - perf_flush_cnt increments per branch flush.
  - perf_lu_cnt increments per load-use bubble.
- Undefined: the counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with instr_E=DIV → all enables 1, flushes 0, mdu_start 0; after release, state IDLE.
- instr_E=MUL x3,x1,x2 (0x022081B3) with MUL_LAT=2 → mdu_start high 1 cycle; pc_enable=0 for 2 cycles; DONE on cycle 3 with enables 1; no second mdu_start.
- instr_E=DIV (0x0220C1B3) with DIV_LAT=33 → mdu_busy high 32 cycles; pc_enable low 33 cycles; reassert rst at cycle 10 → immediate return to defaults, IDLE.
- instr_E=LW x5,0(x1), instr_D=ADD x6,x5,x7 → pc_enable=0, IF_ID_enable=0, ID_EX_flush=1 for 1 cycle; with instr_D=LUI x5 → no stall; with rd_E=x0 → no stall.
- instr_E=BEQ, is_taken=1 → IF_ID_flush=1, ID_EX_flush=1, ID_EX_enable=0, pc_enable=1; is_taken=1 with instr_E=ADD → defaults.
- MUL immediately followed by MUL with MUL_LAT=1 → mdu_start pulses exactly twice, cycles 0 and 2.
